// File: rtl/viterbi_k3_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 hard-decision Viterbi decoder.
// State s = {u_t, u_(t-1)}; the encoder register for branch p_b -> s is {s, b}.
package viterbi_k3_pkg;

   localparam int K       = 3;
   localparam int NSTATES = 4;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   // Bit s set means state s starts at PM_MAX; only state 00 starts at 0.
   localparam logic [NSTATES-1:0] INIT_SAT_MASK = 4'b1110;

   function automatic logic [1:0] expected_sym(input logic [1:0] s, input logic b);
      logic [K-1:0] enc_reg;
      enc_reg = {s, b};
      return {^(enc_reg & G0), ^(enc_reg & G1)};
   endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: two saturated candidates, strict-less select (ties keep b=0).
module acs_cell
   import viterbi_k3_pkg::*;
#(
   parameter int         PM_W  = 4,
   parameter logic [1:0] STATE = 2'd0
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [1:0]      sym,
   output logic [PM_W-1:0] new_pm,
   output logic            decision
);

   localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};
   localparam logic [1:0]      EXP0   = expected_sym(STATE, 1'b0);
   localparam logic [1:0]      EXP1   = expected_sym(STATE, 1'b1);

   logic [1:0]      diff0, diff1;
   logic [1:0]      bm0, bm1;
   logic [PM_W:0]   sum0, sum1;
   logic [PM_W-1:0] cand0, cand1;

   always_comb begin
      diff0 = sym ^ EXP0;
      diff1 = sym ^ EXP1;
      bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
      bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};
      sum0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
      sum1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
      // Clamp instead of wrapping so a saturated path never looks cheap.
      cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
      cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
      decision = (cand1 < cand0);
      new_pm   = decision ? cand1 : cand0;
   end

endmodule

// File: rtl/acs_k3.sv
// ACS stage for the 4-state Viterbi decoder: metric registers, min-finder/normalizer,
// and the registered survivor/best-state words consumed by the traceback.
module acs_k3
   import viterbi_k3_pkg::*;
#(
   parameter int PM_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic                frame_start,
   input  logic [1:0]          sym,
   output logic [NSTATES-1:0]  acs_out,
   output logic [1:0]          small_state,
   output logic                out_valid
);

   localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

   function automatic logic [NSTATES-1:0][PM_W-1:0] build_init();
      logic [NSTATES-1:0][PM_W-1:0] v;
      for (int i = 0; i < NSTATES; i++) begin
         v[i] = INIT_SAT_MASK[i] ? PM_MAX : '0;
      end
      return v;
   endfunction

   localparam logic [NSTATES-1:0][PM_W-1:0] INIT_PM = build_init();

   logic [NSTATES-1:0][PM_W-1:0] pm_q;
   logic [NSTATES-1:0][PM_W-1:0] pm_src;
   logic [NSTATES-1:0][PM_W-1:0] new_pm;
   logic [NSTATES-1:0][PM_W-1:0] norm_pm;
   logic [NSTATES-1:0]           dec;
   logic [PM_W-1:0]              min_val;
   logic [1:0]                   min_idx;

   // A frame start processes this symbol against the initial metrics, not the stored ones.
   assign pm_src = frame_start ? INIT_PM : pm_q;

   for (genvar g = 0; g < NSTATES; g++) begin : g_cell
      acs_cell #(
         .PM_W  (PM_W),
         .STATE (2'(g))
      ) u_cell (
         .pm0      (pm_src[(g % 2) * 2]),
         .pm1      (pm_src[(g % 2) * 2 + 1]),
         .sym      (sym),
         .new_pm   (new_pm[g]),
         .decision (dec[g])
      );
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      min_val = new_pm[0];
      min_idx = 2'd0;
      for (int i = 1; i < NSTATES; i++) begin
         if (new_pm[i] < min_val) begin
            min_val = new_pm[i];
            min_idx = 2'(i);
         end
      end
      for (int i = 0; i < NSTATES; i++) begin
         norm_pm[i] = new_pm[i] - min_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_q        <= INIT_PM;
         acs_out     <= '0;
         small_state <= '0;
         out_valid   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            pm_q        <= norm_pm;
            acs_out     <= dec;
            small_state <= min_idx;
         end
      end
   end

endmodule

// File: tb/tb_acs_k3.sv
// Scoreboard bench for acs_k3: directed symbol streams with hand-derived best states and
// survivor words, plus an independent shift-register reference model for the metrics.
module tb_acs_k3;

   localparam int         PM_W    = 4;
   localparam logic [15:0] INIT_PM = 16'hFFF0;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       frame_start;
   logic [1:0] sym;
   logic [3:0] acs_out;
   logic [1:0] small_state;
   logic       out_valid;

   acs_k3 #(.PM_W(PM_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .sym         (sym),
      .acs_out     (acs_out),
      .small_state (small_state),
      .out_valid   (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  acs;
      logic [1:0]  ss;
      logic [15:0] pm;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   model_pm [4];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      n_cmp++;
      if (actual !== required) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
      end
   endtask

   // Encoder register {u_t, u_(t-1), u_(t-2)}; predecessor is its low two bits.
   task automatic modelStep(input logic fs, input logic [1:0] sv, output exp_t e);
      int   base [4];
      int   newpm [4];
      int   cand [2];
      int   mn;
      int   mi;
      logic [2:0] r;
      logic c0, c1;
      for (int s = 0; s < 4; s++) base[s] = fs ? ((s == 0) ? 0 : 15) : model_pm[s];
      e.acs = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         for (int b = 0; b < 2; b++) begin
            r = {2'(s), 1'(b)};
            c0 = r[2] ^ r[1] ^ r[0];
            c1 = r[2] ^ r[0];
            cand[b] = base[r[1:0]] + int'(c0 != sv[1]) + int'(c1 != sv[0]);
            if (cand[b] > 15) cand[b] = 15;
         end
         if (cand[1] < cand[0]) begin
            e.acs[s] = 1'b1;
            newpm[s] = cand[1];
         end else begin
            newpm[s] = cand[0];
         end
      end
      mn = newpm[0];
      mi = 0;
      for (int s = 1; s < 4; s++) if (newpm[s] < mn) begin mn = newpm[s]; mi = s; end
      e.ss = 2'(mi);
      for (int s = 0; s < 4; s++) model_pm[s] = newpm[s] - mn;
      e.pm = {4'(model_pm[3]), 4'(model_pm[2]), 4'(model_pm[1]), 4'(model_pm[0])};
   endtask

   // hand_mask[1] overrides acs_out, hand_mask[0] overrides small_state with hand values.
   task automatic applyStimulus(input logic fs, input logic [1:0] sv, input logic [1:0] hand_mask,
                                input logic [3:0] hand_acs, input logic [1:0] hand_ss);
      exp_t e;
      in_valid    = 1'b1;
      frame_start = fs;
      sym         = sv;
      modelStep(fs, sv, e);
      if (hand_mask[1]) e.acs = hand_acs;
      if (hand_mask[0]) e.ss  = hand_ss;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic applyIdle(input int n);
      in_valid    = 1'b0;
      frame_start = 1'b1;
      sym         = 2'b11;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      frame_start = 1'b0;
   endtask

   task automatic modelReset();
      sb_q.delete();
      model_pm[0] = 0;
      for (int s = 1; s < 4; s++) model_pm[s] = 15;
      last_exp = '{acs: 4'b0000, ss: 2'b00, pm: INIT_PM};
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_acs_out"}, 32'(acs_out), 32'h0);
      checkOutput({tag, "_small_state"}, 32'(small_state), 32'h0);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      checkOutput({tag, "_pm"}, 32'(dut.pm_q), 32'(INIT_PM));
   endtask

   // Monitor: pop on every valid output, otherwise demand the previous outputs held.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_out_valid", 32'(out_valid), 32'h0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("acs_out", 32'(acs_out), 32'(e.acs));
               checkOutput("small_state", 32'(small_state), 32'(e.ss));
               checkOutput("pm", 32'(dut.pm_q), 32'(e.pm));
               last_exp = e;
            end
         end else begin
            checkOutput("hold_acs_out", 32'(acs_out), 32'(last_exp.acs));
            checkOutput("hold_small_state", 32'(small_state), 32'(last_exp.ss));
            checkOutput("hold_pm", 32'(dut.pm_q), 32'(last_exp.pm));
         end
      end
   end

   // Encoder input 1,0,1,1 from state 00 produces symbols 11,10,00,01.
   logic [1:0] clean_sym [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
   logic [1:0] clean_ss  [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
   logic [3:0] clean_acs [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
   logic [1:0] err_sym   [4] = '{2'b11, 2'b11, 2'b00, 2'b01};
   logic [1:0] err_ss    [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
   logic [3:0] err_acs   [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0111};

   initial begin
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      sym         = 2'b00;
      modelReset();
      #1 rst_n = 1'b0;
      #1 checkResetState("reset");
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean frame; after the first symbol pm[2]=0 and pm[0]=2.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i == 0, clean_sym[i], 2'b11, clean_acs[i], clean_ss[i]);
         if (i == 0) begin
            checkOutput("first_pm2", 32'(dut.pm_q[2]), 32'h0);
            checkOutput("first_pm0", 32'(dut.pm_q[0]), 32'h2);
         end
      end

      // Idle gap with a stray frame_start, then the stream continues from held metrics.
      applyIdle(3);
      applyStimulus(1'b0, 2'b01, 2'b00, 4'b0, 2'b0);
      applyStimulus(1'b0, 2'b11, 2'b00, 4'b0, 2'b0);
      applyStimulus(1'b0, 2'b00, 2'b00, 4'b0, 2'b0);

      // Same frame with the second symbol corrupted.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i == 0, err_sym[i], 2'b11, err_acs[i], err_ss[i]);
      end

      // All-zero stream stays in state 00.
      applyStimulus(1'b1, 2'b00, 2'b11, 4'b0000, 2'b00);
      for (int i = 0; i < 19; i++) begin
         applyStimulus(1'b0, 2'b00, 2'b01, 4'b0, 2'b00);
      end
      checkOutput("zero_pm0", 32'(dut.pm_q[0]), 32'h0);

      // frame_start mid-stream reloads the initial metrics.
      applyStimulus(1'b1, 2'b11, 2'b11, 4'b0000, 2'b10);
      applyStimulus(1'b0, 2'b10, 2'b11, 4'b0000, 2'b01);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 checkResetState("async");
      modelReset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 2'b11, 2'b11, 4'b0000, 2'b10);
      applyStimulus(1'b0, 2'b10, 2'b11, 4'b0000, 2'b01);

      // After reset the first symbol behaves as a frame start even without frame_start.
      @(negedge clk);
      #1 rst_n = 1'b0;
      modelReset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'b11, 2'b11, 4'b0000, 2'b10);

      applyIdle(2);
      checkOutput("queue_drained", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
